// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//   Instruction-fetch stage of the MIPS core. Owns the fetch PC, issues word
//   fetches to a variable-latency instruction memory, keeps up to DEPTH
//   in-order instructions in a prefetch ring, and hands {instr, pc, pc+4} to
//   decode over valid/ready. A branch redirect flushes the ring. Responses to
//   requests that were in flight at the flush are counted and discarded.
//
// Parameters
//   DEPTH     prefetch slots and in-flight limit (power of 2, >= 2)
//   RESET_PC  fetch PC loaded by reset
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr fetch request channel (word aligned)
//   imem_rsp_valid, imem_rsp_data   in-order read data from memory
//   instr_valid/ready               head-of-buffer handshake to decode
//   instr_data, instr_pc,
//   instr_pcplus4                   head instruction, its PC and PC+4
//   redirect_valid, redirect_pc     taken branch/jump: flush and refetch
//
// Optional feature (macro FETCH_PERF_EN)
//   Adds perf_issued / perf_dropped: saturating counts of request handshakes
//   and discarded responses.
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_dropped,
`endif
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW:0]   LIMIT   = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     count_q, count_d;   // reserved slots
    logic [CW-1:0]     pend_q, pend_d;     // reserved slots still awaiting data
    logic [CW-1:0]     drop_q, drop_d;     // responses owed to flushed requests
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [31:0]       slot_pc_q   [DEPTH];
    logic [31:0]       slot_pc_d   [DEPTH];
    logic [31:0]       slot_data_q [DEPTH];
    logic [31:0]       slot_data_d [DEPTH];
    logic              started_q;

    logic issue_hs;
    logic pop;
    logic fill_en;
    logic rsp_discard;
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    // started_q holds requests off while in reset and for the first edge out
    // of it, so imem_req_valid reads 0 whenever rst_n is low.
    assign imem_req_valid = started_q && !redirect_valid &&
                            (({1'b0, count_q} + {1'b0, drop_q}) < LIMIT);
    assign imem_addr      = fetch_pc_q;

    assign instr_valid    = (count_q != '0) && filled_q[head_q];
    assign instr_data     = instr_valid ? slot_data_q[head_q] : '0;
    assign instr_pc       = instr_valid ? slot_pc_q[head_q] : '0;
    assign instr_pcplus4  = instr_valid ? (slot_pc_q[head_q] + 32'd4) : '0;

    assign issue_hs = imem_req_valid && imem_req_ready;
    assign pop      = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        count_d     = count_q;
        pend_d      = pend_q;
        drop_d      = drop_q;
        filled_d    = filled_q;
        slot_pc_d   = slot_pc_q;
        slot_data_d = slot_data_q;
        fill_en     = 1'b0;
        rsp_discard = 1'b0;

        if (redirect_valid) begin
            // Every outstanding request becomes a drop; a response landing in
            // this same cycle already pays off one of them.
            rsp_discard = imem_rsp_valid && ((drop_q != '0) || (pend_q != '0));
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            count_d     = '0;
            pend_d      = '0;
            filled_d    = '0;
            drop_d      = drop_q + pend_q - (rsp_discard ? CNT_ONE : '0);
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_ONE;
            end
            if (issue_hs) begin
                slot_pc_d[tail_q] = fetch_pc_q;
                filled_d[tail_q]  = 1'b0;
                tail_d            = tail_q + PTR_ONE;
                fetch_pc_d        = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    rsp_discard = 1'b1;
                    drop_d      = drop_q - CNT_ONE;
                end else if (pend_q != '0) begin
                    fill_en             = 1'b1;
                    slot_data_d[fill_q] = imem_rsp_data;
                    filled_d[fill_q]    = 1'b1;
                    fill_d              = fill_q + PTR_ONE;
                end
            end
            count_d = count_q + (issue_hs ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            pend_d  = pend_q + (issue_hs ? CNT_ONE : '0) - (fill_en ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            drop_q      <= '0;
            filled_q    <= '0;
            slot_pc_q   <= '{default: '0};
            slot_data_q <= '{default: '0};
            started_q   <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            filled_q    <= filled_d;
            slot_pc_q   <= slot_pc_d;
            slot_data_q <= slot_data_d;
            started_q   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_dropped_q <= '0;
        end else begin
            if (issue_hs && (perf_issued_q != '1)) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (rsp_discard && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 32'd1;
            end
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_dropped = perf_dropped_q;
`endif

    // A response with nothing awaiting data and nothing owed is ignored.
    spurious_rsp_a: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((drop_q != '0) || (pend_q != '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//   Bench for fetch_prefetch_unit. A behavioural instruction memory answers
//   requests in order with random latency. Each redirect/reset pushes the
//   expected sequential instruction stream into a scoreboard queue; a monitor
//   process pops it on every decode handshake and also tracks the expected
//   request address stream.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_dropped;
`endif

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef FETCH_PERF_EN
        .perf_issued    (perf_issued),
        .perf_dropped   (perf_dropped),
`endif
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'hA5A50F0F;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        p = {pc[31:2], 2'b00};
        sb.delete();
        for (int i = 0; i < 128; i++) begin
            sb.push_back('{pc: p, data: mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int lat_min = 1;
    int lat_max = 1;
    int rdy_pct = 100;

    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                imem_req_ready = ($urandom_range(99) < rdy_pct);
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
            #1;
            if (rst_n && imem_req_valid && imem_req_ready)
                mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] req_pc_m;
    logic        prev_wait;
    logic [31:0] prev_addr;
    int          hs_count  = 0;
    int          pop_count = 0;
    int          wrap_seen = 0;
    logic        first_hs_seen;
    logic [31:0] first_hs_addr;
    logic [31:0] last_hs_addr;
    logic        first_pop_seen;
    logic [31:0] first_pop_pc;
    exp_t        e;

    initial begin
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                req_pc_m  = RESET_PC;
                prev_wait = 1'b0;
            end else begin
                if (redirect_valid) chk("no_req_in_redirect", imem_req_valid, 1'b0);
                if (prev_wait) chk("addr_hold", imem_addr, prev_addr);
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_addr, req_pc_m);
                    chk("inflight_le_depth", mq.size() <= DEPTH, 1'b1);
                    if (!first_hs_seen) begin
                        first_hs_seen = 1'b1;
                        first_hs_addr = imem_addr;
                    end
                    last_hs_addr = imem_addr;
                    req_pc_m     = req_pc_m + 32'd4;
                    hs_count++;
                end
                if (redirect_valid) req_pc_m = {redirect_pc[31:2], 2'b00};
                prev_wait = imem_req_valid && !imem_req_ready;
                prev_addr = imem_addr;
                if (instr_valid && instr_ready && !redirect_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_underflow: got pop pc %h expected no output", instr_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("instr_pc", instr_pc, e.pc);
                        chk("instr_data", instr_data, e.data);
                        chk("instr_pcplus4", instr_pcplus4, e.pc + 32'd4);
                        if (!first_pop_seen) begin
                            first_pop_seen = 1'b1;
                            first_pop_pc   = instr_pc;
                        end
                        if (e.pc == 32'hFFFFFFFC) wrap_seen++;
                        pop_count++;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic restart_tracking(input logic [31:0] pc);
        sb_restart(pc);
        first_hs_seen  = 1'b0;
        first_pop_seen = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the redirect cycle.
    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart_tracking(pc);
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_instr_data"}, instr_data, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
        chk({tag, "_instr_pcplus4"}, instr_pcplus4, 32'h0);
    endtask

    initial begin
        #500000;
        n_checks++;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        int p0;
        int w0;
        int len;
        rst_n          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        first_hs_seen  = 1'b0;
        first_pop_seen = 1'b0;
        first_hs_addr  = '0;
        first_pop_pc   = '0;
        last_hs_addr   = '0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        check_outputs_zero("reset");
        chk("reset_addr", imem_addr, RESET_PC);

        // T1: zero-wait streaming
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        restart_tracking(RESET_PC);
        h0 = hs_count;
        p0 = pop_count;
        repeat (20) @(negedge clk);
        chk("t1_first_addr", first_hs_addr, RESET_PC);
        chk("t1_issue_rate", (hs_count - h0) >= 18, 1'b1);
        chk("t1_pop_rate", (pop_count - p0) >= 15, 1'b1);

        // T2: decode stalled, buffer fills to DEPTH
        instr_ready = 1'b0;
        do_redirect(32'h0);
        h0 = hs_count;
        repeat (15) @(negedge clk);
        chk("t2_hs_count", hs_count - h0, DEPTH);
        chk("t2_req_stalled", imem_req_valid, 1'b0);
        p0 = pop_count;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        h0 = hs_count;
        repeat (5) @(negedge clk);
        chk("t2_one_pop", pop_count - p0, 1);
        chk("t2_one_more_hs", hs_count - h0, 1);
        chk("t2_next_addr", last_hs_addr, 32'h10);

        // T3: redirect with three requests in flight
        lat_min = 3;
        lat_max = 3;
        do_redirect(32'h200);
        for (int i = 0; i < 20 && mq.size() != 3; i++) @(negedge clk);
        chk("t3_three_inflight", mq.size(), 3);
        instr_ready = 1'b1;
        do_redirect(32'h40);
        for (int i = 0; i < 40 && !first_pop_seen; i++) @(negedge clk);
        chk("t3_first_pop_seen", first_pop_seen, 1'b1);
        chk("t3_first_pop_pc", first_pop_pc, 32'h40);

        // T4: response coincides with redirect; unaligned target
        lat_min = 1;
        lat_max = 1;
        do_redirect(32'h300);
        for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].due <= cyc); i++) @(negedge clk);
        do_redirect(32'h103);
        for (int i = 0; i < 20 && !first_pop_seen; i++) @(negedge clk);
        chk("t4_first_hs_addr", first_hs_addr, 32'h100);
        chk("t4_first_pop_pc", first_pop_pc, 32'h100);

        // T5: PC wrap
        w0 = wrap_seen;
        do_redirect(32'hFFFFFFF8);
        repeat (12) @(negedge clk);
        chk("t5_wrap_pop", wrap_seen != w0, 1'b1);

        // T6: async reset mid-stream
        lat_min     = 2;
        lat_max     = 2;
        instr_ready = 1'b0;
        do_redirect(32'h80);
        repeat (10) @(negedge clk);
        chk("t6_valid_before_reset", instr_valid, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        restart_tracking(RESET_PC);
        #3;
        chk("t6_addr_after_reset", imem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
        chk("t6_perf_issued", perf_issued, 32'h0);
        chk("t6_perf_dropped", perf_dropped, 32'h0);
`endif

        // Randomized segments with redirects, some back-to-back
        p0 = pop_count;
        for (int s = 0; s < 30; s++) begin
            lat_min = int'($urandom_range(3, 1));
            lat_max = lat_min + int'($urandom_range(3, 0));
            rdy_pct = int'($urandom_range(100, 40));
            len     = int'($urandom_range(60, 10));
            repeat (len) begin
                @(negedge clk);
                instr_ready = ($urandom_range(99) < 70);
            end
            do_redirect($urandom);
            if ($urandom_range(3) == 0) do_redirect($urandom);
        end
        chk("random_progress", (pop_count - p0) >= 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
